// File: rtl/gray_ptr_sync.sv
// rtl/gray_ptr_sync.sv - Gray pointer synchroniser with binary conversion, change pulse and sticky jump error
// Brings a Gray-coded pointer from a foreign domain through a flop chain and reports
// its binary value, one-cycle change pulses and illegal multi-bit transitions.
module gray_ptr_sync #(
    parameter int Width  = 4,
    parameter int Stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] gray_in,
    input  logic             err_clr,
    output logic [Width-1:0] gray_out,
    output logic [Width-1:0] bin_out,
    output logic             valid,
    output logic             chg,
    output logic             err
);

    localparam int CntW = $clog2(Stages + 2);
    localparam logic [CntW-1:0] CntMax = CntW'(Stages + 1);

    logic [Width-1:0] sync_q [Stages];
    logic [Width-1:0] sync_d [Stages];
    logic [Width-1:0] last_q, last_d;
    logic [Width-1:0] bin_q, bin_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;
    logic             err_q, err_d;
    logic [Width-1:0] diff;
    logic             violation;

    function automatic logic [Width-1:0] gray2bin(input logic [Width-1:0] g);
        logic [Width-1:0] b;
        b = '0;
        b[Width-1] = g[Width-1];
        for (int i = Width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign gray_out = sync_q[Stages-1];

    always_comb begin
        sync_d[0] = gray_in;
        for (int k = 1; k < Stages; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // More than one bit set in the xor means a jump a real Gray counter cannot make.
    always_comb begin
        diff      = gray_out ^ last_q;
        violation = |(diff & (diff - Width'(1)));
    end

    always_comb begin
        last_d  = gray_out;
        bin_d   = gray2bin(gray_out);
        cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        valid_d = (cnt_d == CntMax);
        chg_d   = valid_q & (gray_out != last_q);
        err_d   = (err_q & ~err_clr) | (valid_q & violation);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Stages; k++) begin
                sync_q[k] <= '0;
            end
            last_q  <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int k = 0; k < Stages; k++) begin
                sync_q[k] <= sync_d[k];
            end
            last_q  <= last_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    assign bin_out = bin_q;
    assign valid   = valid_q;
    assign chg     = chg_q;
    assign err     = err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb/tb_gray_ptr_sync.sv - directed self-checking bench for gray_ptr_sync
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gray_in;
    logic       err_clr;

    logic [3:0] gray_out, bin_out;
    logic       valid, chg, err;
    logic [3:0] gray_out3, bin_out3;
    logic       valid3, chg3, err3;

    int n_assert = 0;
    int n_fail   = 0;
    int chg_count;
    logic [3:0] b;

    always #5 clk = ~clk;

    gray_ptr_sync #(.Width(4), .Stages(2)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .gray_out(gray_out), .bin_out(bin_out), .valid(valid), .chg(chg), .err(err)
    );

    gray_ptr_sync #(.Width(4), .Stages(3)) dut3 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
        .gray_out(gray_out3), .bin_out(bin_out3), .valid(valid3), .chg(chg3), .err(err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gray_out"}, 32'(gray_out), 32'h0);
        chk({tag, " bin_out"},  32'(bin_out),  32'h0);
        chk({tag, " valid"},    32'(valid),    32'h0);
        chk({tag, " chg"},      32'(chg),      32'h0);
        chk({tag, " err"},      32'(err),      32'h0);
    endtask

    initial begin
        rst = 1'b1; gray_in = 4'b0000; err_clr = 1'b0;

        // reset and startup
        tick(); chk_all_zero("rst_e1");
        tick(); chk_all_zero("rst_e2");
        chk("rst_valid3", 32'(valid3), 32'h0);
        rst = 1'b0;
        tick(); chk("start_e1_valid", 32'(valid), 32'h0);
        tick(); chk("start_e2_valid", 32'(valid), 32'h0);
        tick(); chk("start_e3_valid", 32'(valid), 32'h1);
        chk("start_e3_valid3", 32'(valid3), 32'h0);
        tick(); chk("start_e4_valid3", 32'(valid3), 32'h1);
        chk("start_chg", 32'(chg), 32'h0);

        // latency 0000 -> 0001
        gray_in = 4'b0001;
        tick(); chk("lat_e1_gray", 32'(gray_out), 32'h0);
        tick(); chk("lat_e2_gray", 32'(gray_out), 32'h1);
        chk("lat_e2_bin", 32'(bin_out), 32'h0);
        chk("lat_e2_gray3", 32'(gray_out3), 32'h0);
        tick(); chk("lat_e3_bin", 32'(bin_out), 32'h1);
        chk("lat_e3_chg", 32'(chg), 32'h1);
        chk("lat_e3_gray3", 32'(gray_out3), 32'h1);
        chk("lat_e3_bin3", 32'(bin_out3), 32'h0);
        tick(); chk("lat_e4_chg", 32'(chg), 32'h0);
        chk("lat_e4_bin3", 32'(bin_out3), 32'h1);
        chk("lat_e4_chg3", 32'(chg3), 32'h1);
        tick(); chk("lat_e5_chg3", 32'(chg3), 32'h0);
        chk("lat_e5_err", 32'(err), 32'h0);

        // count and wrap: 16-code sequence twice, starting from 0001
        chg_count = 0;
        for (int i = 0; i < 32; i++) begin
            b = 4'(i % 16);
            gray_in = b ^ (b >> 1);
            for (int c = 0; c < 4; c++) begin
                tick();
                chg_count += int'(chg);
            end
            chk($sformatf("count_bin_%0d", i), 32'(bin_out), 32'(i % 16));
        end
        chk("count_chg_pulses", 32'(chg_count), 32'd32);
        chk("count_err", 32'(err), 32'h0);

        // illegal jump 0000 -> 0011
        gray_in = 4'b0000;
        repeat (4) tick();
        chk("jump_pre_err", 32'(err), 32'h0);
        gray_in = 4'b0011;
        tick(); chk("jump_e1_err", 32'(err), 32'h0);
        tick(); chk("jump_e2_err", 32'(err), 32'h0);
        tick(); chk("jump_e3_err", 32'(err), 32'h1);
        chk("jump_e3_bin", 32'(bin_out), 32'h2);
        tick(); chk("jump_hold_err", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick(); chk("jump_clr_err", 32'(err), 32'h0);
        err_clr = 1'b0;
        tick(); chk("jump_clr_stay", 32'(err), 32'h0);
        gray_in = 4'b0101;
        tick(); tick();
        err_clr = 1'b1;
        tick(); chk("jump_set_wins", 32'(err), 32'h1);
        err_clr = 1'b0;
        gray_in = 4'b0111;
        tick(); tick(); tick();
        chk("jump_bin_0101", 32'(bin_out), 32'h5);
        chk("jump_err_held", 32'(err), 32'h1);

        // reset mid-run
        gray_in = 4'b0110;
        rst = 1'b1;
        tick(); chk_all_zero("midrst");
        rst = 1'b0;
        tick(); chk("mid_e1_chg", 32'(chg), 32'h0); chk("mid_e1_err", 32'(err), 32'h0);
        chk("mid_e1_valid", 32'(valid), 32'h0);
        tick(); chk("mid_e2_chg", 32'(chg), 32'h0); chk("mid_e2_err", 32'(err), 32'h0);
        chk("mid_e2_gray", 32'(gray_out), 32'h6);
        tick(); chk("mid_e3_chg", 32'(chg), 32'h0); chk("mid_e3_err", 32'(err), 32'h0);
        chk("mid_e3_valid", 32'(valid), 32'h1);
        chk("mid_e3_bin", 32'(bin_out), 32'h4);
        tick(); chk("mid_e4_chg", 32'(chg), 32'h0); chk("mid_e4_err", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync.md
GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 Parameter Width, default 4: bit width of the Gray-coded pointer; legal range 2..16.
REQ-002 Parameter Stages, default 2: number of synchroniser flops; legal range 2..4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 gray_in  input  Width  Gray-coded pointer from a foreign clock domain; may change at any time.
REQ-006 err_clr  input  1  synchronous clear of the sticky error flag.
REQ-007 gray_out  output  Width  synchronised Gray value, the last stage of the chain.
REQ-008 bin_out  output  Width  registered binary equivalent of gray_out.
REQ-009 valid  output  1  high once the chain holds only post-reset samples.
REQ-010 chg  output  1  one-cycle pulse when the synchronised pointer changes.
REQ-011 err  output  1  sticky flag: illegal multi-bit Gray transition detected.

Function
REQ-012 The chain SHALL be registered: s[0] <= gray_in, and s[k] <= s[k-1] for k = 1..Stages-1.
REQ-013 gray_out SHALL equal s[Stages-1].
- A gray_in value stable before edge n appears on gray_out after edge n+Stages-1, i.e. Stages edges of latency.
REQ-014 Each edge SHALL perform bin_q <= gray2bin(gray_out), with bin[Width-1] = g[Width-1] and bin[i] = bin[i+1] XOR g[i].
- bin_out therefore lags gray_out by one edge; total latency is Stages+1 edges.
REQ-015 Each edge SHALL perform last_q <= gray_out, holding the previous synchronised value.
REQ-016 A startup counter SHALL count the edges with rst low, saturating at Stages+1.
- valid SHALL be 0 until the counter saturates, then 1.
- valid rises on the (Stages+1)th edge after reset release.
REQ-017 chg SHALL update each edge as chg <= valid AND (gray_out != last_q).
- It is a single-cycle pulse per change.
- It asserts on the same edge that bin_out takes the new value.
REQ-018 The error check SHALL use popcount(gray_out XOR last_q) > 1 as the violation term, gated by valid.
REQ-019 err SHALL update as err <= (err AND NOT err_clr) OR (valid AND violation).
- If err_clr and a new violation occur on the same edge, set wins and err stays 1.
REQ-020 Wrap-around SHALL need no special case.
- The transition from top code 100..0 to 000..0 is a one-bit change and is legal.
- bin_out wraps from 2^Width-1 to 0.
REQ-021 A held, unchanged gray_in SHALL produce no chg pulses and SHALL leave err unchanged.
REQ-022 No combinational path SHALL exist from any input to any output; all outputs are flop outputs.

Reset
REQ-023 While rst=1 at an edge, all state SHALL clear to 0 on that edge.
- State: s[*], last_q, bin_q, chg, err, the startup counter and valid.
REQ-024 rst SHALL take priority over err_clr and all other updates.
REQ-025 Reset asserted mid-operation SHALL restart the startup sequence.
- chg and err stay 0 for Stages+1 edges after release, whatever the value of gray_in.

Verification (Width=4, Stages=2 unless stated)
REQ-026 Reset and startup: hold rst for 2 edges, then release.
- All outputs are 0 during reset.
- valid rises exactly on the 3rd edge after release.
REQ-027 Latency: after valid, gray_in goes 0000->0001 between edges.
- gray_out = 0001 after 2 edges.
- bin_out = 0001 and chg = 1 after 3 edges.
- chg = 0 on the following edge.
REQ-028 Count and wrap: drive the 16-code Gray sequence twice, one code every 4 cycles.
- bin_out steps 0..15, 0..15.
- There are 32 chg pulses and err stays 0, including across 1000->0000.
REQ-029 Illegal jump: after valid, gray_in goes 0000->0011.
- err = 1 three edges later and holds.
- An err_clr pulse clears err on the next edge.
- err_clr on the same edge as a new violation (0011->0101) leaves err = 1.
REQ-030 Reset mid-run: with err = 1 and bin_out = 0101, assert rst for 1 edge while gray_in = 0110.
- All outputs go to 0.
- No chg or err occurs during the 3 startup edges.
- bin_out = 0100 once valid.
REQ-031 Stages=3: repeat REQ-027.
- gray_out appears after 3 edges, bin_out after 4 edges.
- valid rises on the 4th edge after reset release.
